// File: rtl/uc_secuenciador.sv
// Two-phase (FETCH/EXEC) control unit for the microc datapath with a return-address stack, HALT and FAULT.
// Optional macro UC_ILLEGAL_TRAP_EN: illegal opcodes trap to FAULT instead of executing as NOP.
module uc_secuenciador #(
    parameter int STACK_DEPTH = 4,
    parameter int AW          = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [5:0]    opcode,
    input  logic          z,
    input  logic [AW-1:0] pc_plus1,
    output logic          pc_en,
    output logic          s_inc,
    output logic          s_ret,
    output logic [AW-1:0] ret_addr,
    output logic          s_inm,
    output logic          we3,
    output logic          wez,
    output logic [2:0]    Op,
    output logic          halted,
    output logic          fault
);
    localparam int IW  = $clog2(STACK_DEPTH);
    localparam int SPW = IW + 1;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_EXEC,
        ST_HALT,
        ST_FAULT
    } state_t;

    state_t          state_reg, state_next;
    logic [SPW-1:0]  sp_reg, sp_next;
    logic [SPW-1:0]  sp_m1;
    logic            push;
    logic            stack_full;
    logic            stack_empty;
    logic [AW-1:0]   stack_reg [STACK_DEPTH];

    assign stack_full  = (sp_reg == SPW'(STACK_DEPTH));
    assign stack_empty = (sp_reg == '0);
    assign sp_m1       = sp_reg - SPW'(1);
    assign ret_addr    = stack_empty ? '0 : stack_reg[sp_m1[IW-1:0]];

    assign halted = (state_reg == ST_HALT);
    assign fault  = (state_reg == ST_FAULT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_FETCH;
            sp_reg    <= '0;
        end else begin
            state_reg <= state_next;
            sp_reg    <= sp_next;
        end
    end

    // push is only raised while sp < STACK_DEPTH, so the low bits always index a valid entry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_reg[i] <= '0;
            end
        end else if (push) begin
            stack_reg[sp_reg[IW-1:0]] <= pc_plus1;
        end
    end

    always_comb begin
        state_next = state_reg;
        sp_next    = sp_reg;
        push       = 1'b0;
        pc_en      = 1'b0;
        s_inc      = 1'b1;
        s_ret      = 1'b0;
        s_inm      = 1'b0;
        we3        = 1'b0;
        wez        = 1'b0;
        Op         = 3'b000;
        unique case (state_reg)
            ST_FETCH: state_next = ST_EXEC;
            ST_EXEC: begin
                state_next = ST_FETCH;
                if (opcode[5]) begin
                    Op    = opcode[4:2];
                    we3   = 1'b1;
                    wez   = 1'b1;
                    pc_en = 1'b1;
                end else if (opcode[4:2] == 3'b001) begin
                    s_inm = 1'b1;
                    we3   = 1'b1;
                    pc_en = 1'b1;
                end else if (opcode[4:2] == 3'b000) begin
                    pc_en = 1'b1;
                end else begin
                    unique case (opcode[4:0])
                        5'b10000: begin
                            s_inc = 1'b0;
                            pc_en = 1'b1;
                        end
                        5'b10001: begin
                            s_inc = ~z;
                            pc_en = 1'b1;
                        end
                        5'b10010: begin
                            s_inc = z;
                            pc_en = 1'b1;
                        end
                        5'b10011: begin
                            if (stack_full) begin
                                state_next = ST_FAULT;
                            end else begin
                                push    = 1'b1;
                                sp_next = sp_reg + SPW'(1);
                                s_inc   = 1'b0;
                                pc_en   = 1'b1;
                            end
                        end
                        5'b10100: begin
                            if (stack_empty) begin
                                state_next = ST_FAULT;
                            end else begin
                                sp_next = sp_m1;
                                s_ret   = 1'b1;
                                pc_en   = 1'b1;
                            end
                        end
                        5'b11111: state_next = ST_HALT;
                        default: begin
`ifdef UC_ILLEGAL_TRAP_EN
                            state_next = ST_FAULT;
`else
                            pc_en = 1'b1;
`endif
                        end
                    endcase
                end
            end
            ST_HALT:  state_next = ST_HALT;
            ST_FAULT: state_next = ST_FAULT;
            default:  state_next = ST_FETCH;
        endcase
    end
endmodule

// File: tb/tb_uc_secuenciador.sv
// Bench for uc_secuenciador: directed program steps then random opcodes, checked against a queue-based model.
module tb_uc_secuenciador;
    localparam int DEPTH = 4;
    localparam int AW    = 10;
`ifdef UC_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [5:0]    opcode = '0;
    logic          z = 1'b0;
    logic [AW-1:0] pc_plus1 = '0;
    logic          pc_en, s_inc, s_ret, s_inm, we3, wez, halted, fault;
    logic [AW-1:0] ret_addr;
    logic [2:0]    Op;

    always #5 clk = ~clk;

    uc_secuenciador #(.STACK_DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .z(z), .pc_plus1(pc_plus1),
        .pc_en(pc_en), .s_inc(s_inc), .s_ret(s_ret), .ret_addr(ret_addr),
        .s_inm(s_inm), .we3(we3), .wez(wez), .Op(Op), .halted(halted), .fault(fault)
    );

    int errors = 0;
    int checks = 0;
    // phase: 0 fetch, 1 exec, 2 halted, 3 faulted; stk holds return addresses, top at the end
    int phase = 0;
    logic [AW-1:0] stk[$];

    // instruction classes: 0 ALU,1 LI,2 NOP,3 J,4 JZ,5 JNZ,6 JAL,7 RET,8 HALT,9 illegal
    function automatic int cls(input logic [5:0] o);
        int v = int'(o);
        if (v >= 32) return 0;
        if (v / 4 == 1) return 1;
        if (v / 4 == 0) return 2;
        if (v == 16) return 3;
        if (v == 17) return 4;
        if (v == 18) return 5;
        if (v == 19) return 6;
        if (v == 20) return 7;
        if (v == 31) return 8;
        return 9;
    endfunction

    function automatic logic [20:0] expected();
        logic e_pc = 0, e_inc = 1, e_ret = 0, e_inm = 0, e_we3 = 0, e_wez = 0;
        logic [2:0] e_op = 0;
        logic [AW-1:0] e_ra = (stk.size() > 0) ? stk[stk.size()-1] : '0;
        if (phase == 1) begin
            case (cls(opcode))
                0: begin e_op = 3'((int'(opcode) - 32) / 4); e_we3 = 1; e_wez = 1; e_pc = 1; end
                1: begin e_inm = 1; e_we3 = 1; e_pc = 1; end
                2: e_pc = 1;
                3: begin e_inc = 0; e_pc = 1; end
                4: begin e_inc = ~z; e_pc = 1; end
                5: begin e_inc = z; e_pc = 1; end
                6: if (stk.size() < DEPTH) begin e_inc = 0; e_pc = 1; end
                7: if (stk.size() > 0) begin e_ret = 1; e_pc = 1; end
                8: ;
                default: e_pc = !TRAP;
            endcase
        end
        return {e_pc, e_inc, e_ret, e_inm, e_we3, e_wez, e_op, phase == 2, phase == 3, e_ra};
    endfunction

    task automatic check(input string tag);
        logic [20:0] exp_v, got;
        exp_v = expected();
        got = {pc_en, s_inc, s_ret, s_inm, we3, wez, Op, halted, fault, ret_addr};
        checks++;
        assert (got === exp_v) else begin
            errors++;
            $error("FAIL %s: got={pc_en,s_inc,s_ret,s_inm,we3,wez,Op,halted,fault,ret}=%b exp=%b op=%b z=%b",
                   tag, got, exp_v, opcode, z);
        end
    endtask

    task automatic drive_check(input string tag, input logic [5:0] op, input logic zz, input logic [AW-1:0] pc1);
        opcode = op; z = zz; pc_plus1 = pc1;
        #1;
        check(tag);
    endtask

    task automatic advance();
        @(posedge clk);
        if (phase == 0) phase = 1;
        else if (phase == 1) begin
            phase = 0;
            case (cls(opcode))
                6: if (stk.size() < DEPTH) stk.push_back(pc_plus1); else phase = 3;
                7: if (stk.size() > 0) void'(stk.pop_back()); else phase = 3;
                8: phase = 2;
                9: if (TRAP) phase = 3;
                default: ;
            endcase
        end
        @(negedge clk);
    endtask

    task automatic step(input string tag, input logic [5:0] op, input logic zz, input logic [AW-1:0] pc1);
        drive_check(tag, op, zz, pc1);
        advance();
    endtask

    // fetch + exec of one instruction
    task automatic instr(input string tag, input logic [5:0] op, input logic zz, input logic [AW-1:0] pc1);
        step({tag, "_f"}, op, zz, pc1);
        step({tag, "_x"}, op, zz, pc1);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        phase = 0;
        stk.delete();
        check(tag);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        do_reset("rst0");

        instr("li", 6'b000100, 1'b0, 10'h001);
        instr("sub", 6'b100100, 1'b0, 10'h002);
        instr("jz", 6'b010001, 1'b1, 10'h003);
        instr("jnz_z1", 6'b010010, 1'b1, 10'h011);
        instr("jnz_z0", 6'b010010, 1'b0, 10'h012);
        instr("j", 6'b010000, 1'b0, 10'h013);
        for (int i = 0; i < 8; i++) instr("alu", 6'(32 + 4 * i + (i % 4)), 1'b0, 10'h014);

        instr("jal", 6'b010011, 1'b0, 10'h021);
        instr("ret", 6'b010100, 1'b0, 10'h0aa);
        step("after_ret", 6'b000000, 1'b0, 10'h022);

        do_reset("rst_nest");
        for (int i = 0; i < 5; i++) instr("jal_nest", 6'b010011, 1'b0, 10'(16 * i + 5));
        for (int i = 0; i < 3; i++) step("fault_hold", 6'b000100, 1'b0, 10'h0);

        do_reset("rst_empty");
        instr("ret_empty", 6'b010100, 1'b0, 10'h0);
        step("fault_empty", 6'b100000, 1'b0, 10'h0);

        do_reset("rst_halt");
        instr("halt", 6'b011111, 1'b0, 10'h0);
        for (int i = 0; i < 20; i++) step("halt_hold", 6'($urandom), 1'($urandom), 10'($urandom));

        do_reset("rst_mid");
        step("mid_f", 6'b111000, 1'b0, 10'h0);
        drive_check("mid_x", 6'b111000, 1'b0, 10'h0);
        reset = 1'b0;
        #1;
        phase = 0;
        stk.delete();
        check("mid_rst_async");
        @(negedge clk);
        reset = 1'b1;
        instr("post_rst", 6'b000101, 1'b0, 10'h0);

        instr("illegal", 6'b010101, 1'b0, 10'h0);
        step("after_ill", 6'b000000, 1'b0, 10'h0);

        do_reset("rst_rand");
        for (int n = 0; n < 400; n++) begin
            int r;
            logic [5:0] op;
            if (phase >= 2 && $urandom_range(0, 3) == 0) begin
                do_reset("rand_rst");
                continue;
            end
            r = $urandom_range(0, 19);
            if (r < 5) op = 6'(32 + $urandom_range(0, 31));
            else if (r < 7) op = 6'(4 + $urandom_range(0, 3));
            else if (r < 8) op = 6'($urandom_range(0, 3));
            else if (r < 11) op = 6'(16 + $urandom_range(0, 2));
            else if (r < 14) op = 6'd19;
            else if (r < 17) op = 6'd20;
            else if (r < 18) op = 6'd31;
            else op = 6'(21 + $urandom_range(0, 9));
            step("rand", op, 1'($urandom), 10'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
